am2914: RTL and testbench
=========================

Name: am2914

Overview:
- Vectored priority interrupt controller; the encoding counterpart of the existing 3-to-8 decoder.
- Latches 8 interrupt requests, applies a mask and a nesting status threshold, and encodes the highest pending request into a 3-bit vector.
- Sits between device request lines and the microsequencer, which services interrupts via a 4-bit instruction port.

Parameters:
- none. Width is fixed at 8 requests / 3-bit vector, matching the bitslice part.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- irq  in  8  interrupt request levels; bit 7 = highest priority
- instr  in  4  command, executed at rising edge
- d_in  in  8  data for load/clear commands
- d_out  out  8  registered read data
- d_oe  out  1  d_out valid
- vec  out  3  vector register
- int_req  out  1  interrupt request to sequencer
- any_pend  out  1  any unmasked pending bit

Behaviour:
- State registers:
  - pend[7:0]
  - mask[7:0] (1 = masked)
  - status[3:0] (range 0..8)
  - ien
  - vec[2:0]
  - d_out, d_oe
- Reset and MCLR: all registers cleared to 0. Reset has priority over instr and irq.
- Request capture:
  - Every edge, pend <= (pend & ~clr) | irq, where clr is the per-bit clear set by the current instruction.
  - Set beats clear: a request present in the same cycle it is cleared stays pending.
- Encoding: act = pend & ~mask; top = index of highest set bit of act.
  - any_pend = |act.
  - int_req = ien & any_pend & (top >= status).
  - Both are combinational from registers: an irq sampled at edge k is visible after edge k.
  - status = 8 suppresses int_req entirely.
- d_oe is high only for the cycle after a READ_* command, low otherwise. d_out holds its last value.
- Commands (opcode values in the package):
  - 0 NOP.
  - 1 MCLR.
  - 2 CLR_ALL: clr = FF.
  - 3 CLR_BUS: clr = d_in.
  - 4 CLR_VEC: clr = one-hot(vec).
  - 5 READ_VEC:
    - If any_pend & top >= status: vec <= top, clr = one-hot(top), status <= top+1, d_out <= {5'b0, top}.
    - Otherwise nothing changes except d_out <= {5'b0, vec}.
  - 6 LD_STAT: status <= min(d_in[3:0], 8).
  - 7 RD_STAT: d_out <= {4'b0, status}.
  - 8 LD_MASK: mask <= d_in.
  - 9 RD_MASK: d_out <= mask.
  - 10 SET_MASK: mask <= mask | d_in.
  - 11 CLR_MASK: mask <= mask & ~d_in.
  - 12 ENA: ien <= 1.
  - 13 DIS: ien <= 0.
  - 14 RD_PEND: d_out <= pend.
  - 15 NOP.
- Boundary conditions:
  - READ_VEC with top = 7 sets status = 8, which blocks further nesting until LD_STAT.
  - A masked pending bit is retained and becomes active when unmasked, with no re-request needed.
  - READ_VEC ignores ien; ien gates int_req only.
  - Reset mid-service discards pending requests and the vector.

Decomposition:
- Shared package am29_pkg: 4-bit opcode localparams for am2914 (AM2914_NOP .. AM2914_RD_PEND) and the status-disable constant 4'd8.
- Sub-module am2914_prio: combinational 8-to-3 priority encoder with valid output, instantiated once on act.

Test Plan:
- Reset then irq = 8'h24 for one cycle, ENA:
  - pend = 24, top = 5, int_req = 1.
  - READ_VEC gives vec = 5, d_out = 05, d_oe = 1, status = 6, pend = 04, int_req = 0.
- Nesting:
  - With status = 6, irq = 8'h80 raises int_req.
  - READ_VEC gives vec = 7, status = 8.
  - A later irq = 8'h40 keeps int_req = 0 until LD_STAT d_in = 0.
- Mask:
  - LD_MASK FF, irq = 8'h10: pend = 10, any_pend = 0.
  - CLR_MASK 10: any_pend = 1, top = 4. RD_MASK gives d_out = EF.
- Simultaneous set/clear: CLR_BUS d_in = 02 while irq = 02 -> pend[1] stays 1. Next cycle, irq = 0 and CLR_BUS 02 -> pend = 00.
- ien and READ_VEC:
  - DIS with pend = 01: int_req = 0.
  - READ_VEC still returns vec = 0 and clears pend.
  - READ_VEC again on an empty pend leaves vec = 0 and status unchanged.
- Reset mid-operation: pend = FF, mask = 0F, status = 3, ien = 1, then rst for one cycle -> all registers 0, int_req = 0, d_oe = 0.

Source files
------------

// File: rtl/am29_pkg.sv
// Shared opcodes and constants for the am29 bitslice family.
// Opcode values match the 4-bit instruction port of the am2914 interrupt controller.
package am29_pkg;

    localparam logic [3:0] AM2914_NOP      = 4'd0;
    localparam logic [3:0] AM2914_MCLR     = 4'd1;
    localparam logic [3:0] AM2914_CLR_ALL  = 4'd2;
    localparam logic [3:0] AM2914_CLR_BUS  = 4'd3;
    localparam logic [3:0] AM2914_CLR_VEC  = 4'd4;
    localparam logic [3:0] AM2914_READ_VEC = 4'd5;
    localparam logic [3:0] AM2914_LD_STAT  = 4'd6;
    localparam logic [3:0] AM2914_RD_STAT  = 4'd7;
    localparam logic [3:0] AM2914_LD_MASK  = 4'd8;
    localparam logic [3:0] AM2914_RD_MASK  = 4'd9;
    localparam logic [3:0] AM2914_SET_MASK = 4'd10;
    localparam logic [3:0] AM2914_CLR_MASK = 4'd11;
    localparam logic [3:0] AM2914_ENA      = 4'd12;
    localparam logic [3:0] AM2914_DIS      = 4'd13;
    localparam logic [3:0] AM2914_RD_PEND  = 4'd14;
    localparam logic [3:0] AM2914_NOP_F    = 4'd15;

    // A status of 8 is above every vector index, so it disables all requests.
    localparam logic [3:0] AM2914_STAT_DIS = 4'd8;

    function automatic logic [3:0] am2914_sat_status(input logic [3:0] value);
        return (value > AM2914_STAT_DIS) ? AM2914_STAT_DIS : value;
    endfunction

endpackage

// File: rtl/am2914_prio.sv
// Combinational 8-to-3 priority encoder; bit 7 has the highest priority.
// valid is low when no request is set, in which case idx is 0.
module am2914_prio (
    input  logic [7:0] req,
    output logic [2:0] idx,
    output logic       valid
);

    always_comb begin
        idx   = 3'd0;
        valid = 1'b0;
        // Ascending scan: the last set bit seen is the highest one.
        for (int i = 0; i < 8; i++) begin
            if (req[i]) begin
                idx   = 3'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/am2914.sv
// Vectored priority interrupt controller: latches 8 requests, masks them,
// compares the highest against a nesting status and encodes a 3-bit vector.
module am2914
    import am29_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] irq,
    input  logic [3:0] instr,
    input  logic [7:0] d_in,
    output logic [7:0] d_out,
    output logic       d_oe,
    output logic [2:0] vec,
    output logic       int_req,
    output logic       any_pend
);

    logic [7:0] pend_reg, pend_next;
    logic [7:0] mask_reg, mask_next;
    logic [3:0] status_reg, status_next;
    logic       ien_reg, ien_next;
    logic [2:0] vec_reg, vec_next;
    logic [7:0] d_out_reg, d_out_next;
    logic       d_oe_reg, d_oe_next;

    logic [7:0] act;
    logic [2:0] top;
    logic       top_valid;
    logic       top_hit;
    logic [7:0] clr;
    logic [7:0] vec_onehot;
    logic [7:0] top_onehot;

    assign act = pend_reg & ~mask_reg;

    am2914_prio u_prio (
        .req   (act),
        .idx   (top),
        .valid (top_valid)
    );

    // Status 8 can never be reached by a 3-bit top, so it suppresses everything.
    assign top_hit  = top_valid && ({1'b0, top} >= status_reg);
    assign any_pend = top_valid;
    assign int_req  = ien_reg & top_hit;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_onehot
            assign vec_onehot[gi] = (vec_reg == 3'(gi));
            assign top_onehot[gi] = (top == 3'(gi));
        end
    endgenerate

    always_comb begin
        clr         = 8'h00;
        mask_next   = mask_reg;
        status_next = status_reg;
        ien_next    = ien_reg;
        vec_next    = vec_reg;
        d_out_next  = d_out_reg;
        d_oe_next   = 1'b0;

        unique case (instr)
            AM2914_CLR_ALL:  clr = 8'hFF;
            AM2914_CLR_BUS:  clr = d_in;
            AM2914_CLR_VEC:  clr = vec_onehot;
            AM2914_READ_VEC: begin
                d_oe_next = 1'b1;
                if (top_hit) begin
                    vec_next    = top;
                    clr         = top_onehot;
                    status_next = {1'b0, top} + 4'd1;
                    d_out_next  = {5'b0, top};
                end else begin
                    d_out_next  = {5'b0, vec_reg};
                end
            end
            AM2914_LD_STAT:  status_next = am2914_sat_status(d_in[3:0]);
            AM2914_RD_STAT: begin
                d_oe_next  = 1'b1;
                d_out_next = {4'b0, status_reg};
            end
            AM2914_LD_MASK:  mask_next = d_in;
            AM2914_RD_MASK: begin
                d_oe_next  = 1'b1;
                d_out_next = mask_reg;
            end
            AM2914_SET_MASK: mask_next = mask_reg | d_in;
            AM2914_CLR_MASK: mask_next = mask_reg & ~d_in;
            AM2914_ENA:      ien_next  = 1'b1;
            AM2914_DIS:      ien_next  = 1'b0;
            AM2914_RD_PEND: begin
                d_oe_next  = 1'b1;
                d_out_next = pend_reg;
            end
            default: ;
        endcase

        // New requests win over a clear issued in the same cycle.
        pend_next = (pend_reg & ~clr) | irq;
    end

    always_ff @(posedge clk) begin
        if (rst || instr == AM2914_MCLR) begin
            pend_reg   <= 8'h00;
            mask_reg   <= 8'h00;
            status_reg <= 4'd0;
            ien_reg    <= 1'b0;
            vec_reg    <= 3'd0;
            d_out_reg  <= 8'h00;
            d_oe_reg   <= 1'b0;
        end else begin
            pend_reg   <= pend_next;
            mask_reg   <= mask_next;
            status_reg <= status_next;
            ien_reg    <= ien_next;
            vec_reg    <= vec_next;
            d_out_reg  <= d_out_next;
            d_oe_reg   <= d_oe_next;
        end
    end

    assign vec   = vec_reg;
    assign d_out = d_out_reg;
    assign d_oe  = d_oe_reg;

endmodule

// File: tb/tb_am2914.sv
// Self-checking bench for am2914: directed scenarios with literal expectations
// followed by randomized traffic, all checked every cycle against a behavioural model.
module tb_am2914;
    import am29_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] irq;
    logic [3:0] instr;
    logic [7:0] d_in;
    logic [7:0] d_out;
    logic       d_oe;
    logic [2:0] vec;
    logic       int_req;
    logic       any_pend;

    int n_cmp = 0;
    int n_err = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    am2914 dut (
        .clk      (clk),
        .rst      (rst),
        .irq      (irq),
        .instr    (instr),
        .d_in     (d_in),
        .d_out    (d_out),
        .d_oe     (d_oe),
        .vec      (vec),
        .int_req  (int_req),
        .any_pend (any_pend)
    );

    // Behavioural model state.
    logic [7:0] m_pend, m_mask, m_dout;
    int         m_status;
    bit         m_ien, m_doe;
    int         m_vec;

    function automatic int highest(input logic [7:0] v);
        int h = -1;
        for (int i = 0; i < 8; i++) if (v[i]) h = i;
        return h;
    endfunction

    always @(posedge clk) begin
        logic [7:0] act, clr;
        int t;
        act = m_pend & ~m_mask;
        t   = highest(act);
        clr = 8'h00;
        if (rst || instr == AM2914_MCLR) begin
            m_pend = 0; m_mask = 0; m_status = 0; m_ien = 0; m_vec = 0; m_dout = 0; m_doe = 0;
        end else begin
            m_doe = 0;
            case (instr)
                AM2914_CLR_ALL: clr = 8'hFF;
                AM2914_CLR_BUS: clr = d_in;
                AM2914_CLR_VEC: clr = 8'(1 << m_vec);
                AM2914_READ_VEC: begin
                    m_doe = 1;
                    if (t >= 0 && t >= m_status) begin
                        m_vec = t; clr = 8'(1 << t); m_status = t + 1; m_dout = 8'(t);
                    end else begin
                        m_dout = 8'(m_vec);
                    end
                end
                AM2914_LD_STAT: m_status = (d_in[3:0] > 8) ? 8 : int'(d_in[3:0]);
                AM2914_RD_STAT: begin m_doe = 1; m_dout = 8'(m_status); end
                AM2914_LD_MASK: m_mask = d_in;
                AM2914_RD_MASK: begin m_doe = 1; m_dout = m_mask; end
                AM2914_SET_MASK: m_mask = m_mask | d_in;
                AM2914_CLR_MASK: m_mask = m_mask & ~d_in;
                AM2914_ENA: m_ien = 1;
                AM2914_DIS: m_ien = 0;
                AM2914_RD_PEND: begin m_doe = 1; m_dout = m_pend; end
                default: ;
            endcase
            m_pend = (m_pend & ~clr) | irq;
        end
    end

    task automatic chk(input string name, input int act_v, input int exp_v);
        n_cmp++;
        if (act_v != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act_v, exp_v, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (check_en) begin
            int t;
            bit ap, ir;
            t  = highest(m_pend & ~m_mask);
            ap = (t >= 0);
            ir = m_ien && ap && (t >= m_status);
            chk("model.vec", int'(vec), m_vec);
            chk("model.any_pend", int'(any_pend), int'(ap));
            chk("model.int_req", int'(int_req), int'(ir));
            chk("model.d_oe", int'(d_oe), int'(m_doe));
            chk("model.d_out", int'(d_out), int'(m_dout));
        end
    end

    // Apply one command for one edge; returns at the following negedge.
    task automatic cmd(input logic [3:0] op, input logic [7:0] rq, input logic [7:0] din);
        instr = op; irq = rq; d_in = din; rst = 1'b0;
        @(negedge clk);
        $display("cmd op=%0d irq=%02h d_in=%02h -> vec=%0d d_out=%02h d_oe=%0b int_req=%0b any_pend=%0b",
                 op, rq, din, vec, d_out, d_oe, int_req, any_pend);
    endtask

    task automatic do_reset();
        instr = AM2914_NOP; irq = 8'h00; d_in = 8'h00; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        $display("reset -> vec=%0d d_out=%02h d_oe=%0b int_req=%0b", vec, d_out, d_oe, int_req);
    endtask

    initial begin
        rst = 1'b1; irq = 8'h00; instr = AM2914_NOP; d_in = 8'h00;
        @(negedge clk);
        @(negedge clk);
        check_en = 1'b1;
        do_reset();
        chk("reset.vec", int'(vec), 0);
        chk("reset.d_oe", int'(d_oe), 0);
        chk("reset.int_req", int'(int_req), 0);
        chk("reset.any_pend", int'(any_pend), 0);

        // Basic service of irq 24.
        cmd(AM2914_NOP, 8'h24, 8'h00);
        cmd(AM2914_ENA, 8'h00, 8'h00);
        chk("basic.int_req", int'(int_req), 1);
        cmd(AM2914_RD_PEND, 8'h00, 8'h00);
        chk("basic.pend", int'(d_out), 'h24);
        cmd(AM2914_READ_VEC, 8'h00, 8'h00);
        chk("basic.vec", int'(vec), 5);
        chk("basic.d_out", int'(d_out), 'h05);
        chk("basic.d_oe", int'(d_oe), 1);
        chk("basic.int_req_after", int'(int_req), 0);
        cmd(AM2914_RD_STAT, 8'h00, 8'h00);
        chk("basic.status", int'(d_out), 6);
        cmd(AM2914_RD_PEND, 8'h00, 8'h00);
        chk("basic.pend_after", int'(d_out), 'h04);

        // Nesting up to status 8.
        cmd(AM2914_NOP, 8'h80, 8'h00);
        chk("nest.d_oe_low", int'(d_oe), 0);
        chk("nest.int_req", int'(int_req), 1);
        cmd(AM2914_READ_VEC, 8'h00, 8'h00);
        chk("nest.vec", int'(vec), 7);
        cmd(AM2914_RD_STAT, 8'h00, 8'h00);
        chk("nest.status", int'(d_out), 8);
        cmd(AM2914_NOP, 8'h40, 8'h00);
        chk("nest.blocked", int'(int_req), 0);
        chk("nest.any_pend", int'(any_pend), 1);
        cmd(AM2914_LD_STAT, 8'h00, 8'h00);
        chk("nest.unblocked", int'(int_req), 1);

        // Masked request retained until unmasked.
        cmd(AM2914_MCLR, 8'h00, 8'h00);
        cmd(AM2914_LD_MASK, 8'h00, 8'hFF);
        cmd(AM2914_NOP, 8'h10, 8'h00);
        chk("mask.any_pend", int'(any_pend), 0);
        cmd(AM2914_RD_PEND, 8'h00, 8'h00);
        chk("mask.pend", int'(d_out), 'h10);
        cmd(AM2914_CLR_MASK, 8'h00, 8'h10);
        chk("mask.any_pend_on", int'(any_pend), 1);
        cmd(AM2914_RD_MASK, 8'h00, 8'h00);
        chk("mask.rd_mask", int'(d_out), 'hEF);
        cmd(AM2914_READ_VEC, 8'h00, 8'h00);
        chk("mask.vec", int'(vec), 4);

        // Set beats clear.
        cmd(AM2914_MCLR, 8'h00, 8'h00);
        cmd(AM2914_CLR_BUS, 8'h02, 8'h02);
        cmd(AM2914_RD_PEND, 8'h00, 8'h00);
        chk("setclr.kept", int'(d_out), 'h02);
        cmd(AM2914_CLR_BUS, 8'h00, 8'h02);
        cmd(AM2914_RD_PEND, 8'h00, 8'h00);
        chk("setclr.cleared", int'(d_out), 'h00);

        // READ_VEC ignores ien.
        cmd(AM2914_MCLR, 8'h00, 8'h00);
        cmd(AM2914_NOP, 8'h01, 8'h00);
        cmd(AM2914_DIS, 8'h00, 8'h00);
        chk("ien.int_req", int'(int_req), 0);
        chk("ien.any_pend", int'(any_pend), 1);
        cmd(AM2914_READ_VEC, 8'h00, 8'h00);
        chk("ien.vec", int'(vec), 0);
        chk("ien.cleared", int'(any_pend), 0);
        cmd(AM2914_READ_VEC, 8'h00, 8'h00);
        chk("ien.empty_vec", int'(vec), 0);
        cmd(AM2914_RD_STAT, 8'h00, 8'h00);
        chk("ien.status", int'(d_out), 1);

        // Reset mid-operation.
        cmd(AM2914_NOP, 8'hFF, 8'h00);
        cmd(AM2914_LD_MASK, 8'h00, 8'h0F);
        cmd(AM2914_LD_STAT, 8'h00, 8'h03);
        cmd(AM2914_ENA, 8'h00, 8'h00);
        chk("mid.int_req_pre", int'(int_req), 1);
        do_reset();
        chk("mid.int_req", int'(int_req), 0);
        chk("mid.d_oe", int'(d_oe), 0);
        chk("mid.any_pend", int'(any_pend), 0);
        cmd(AM2914_RD_PEND, 8'h00, 8'h00);
        chk("mid.pend", int'(d_out), 0);
        cmd(AM2914_RD_MASK, 8'h00, 8'h00);
        chk("mid.mask", int'(d_out), 0);
        cmd(AM2914_RD_STAT, 8'h00, 8'h00);
        chk("mid.status", int'(d_out), 0);

        // Randomized traffic; the per-cycle compare does the checking.
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] op;
            logic [7:0] rq, din;
            op  = 4'($urandom_range(0, 15));
            if (op == AM2914_MCLR && $urandom_range(0, 3) != 0) op = AM2914_READ_VEC;
            rq  = 8'($urandom & $urandom & $urandom);
            din = 8'($urandom);
            if ($urandom_range(0, 127) == 0) do_reset();
            else cmd(op, rq, din);
        end

        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
